// File: rtl/cla_sub_seq_if.sv
// Valid/ready operand and result bundle for the multi-cycle lookahead subtractor.
interface cla_sub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             zero;

  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, ovf, zero
  );
endinterface

// File: rtl/cla_sub_seq.sv
// Multi-cycle subtractor: diff = a - b - b_in, four bits per clock through one
// 4-bit generate/propagate lookahead slice computing a + ~b + carry.
module cla_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cla_sub_seq_if.slave  io
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       slice_a, slice_nb, slice_sum;
  logic             slice_cout;

  // 4-bit lookahead adder: returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Select the current slice of the captured operands and run it through the lookahead.
  always_comb begin
    slice_a  = a_q[int'(cnt_q) * 4 +: 4];
    slice_nb = ~b_q[int'(cnt_q) * 4 +: 4];
    {slice_cout, slice_sum} = cla4(slice_a, slice_nb, carry_q);
  end

  // Next-state and datapath update for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    b_out_d     = b_out_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d        = io.a;
          b_d        = io.b;
          carry_d    = ~io.b_in;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        diff_d[int'(cnt_q) * 4 +: 4] = slice_sum;
        carry_d = slice_cout;
        if (cnt_q == CW'(NSLICE - 1)) begin
          b_out_d     = ~slice_cout;
          ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d      = (diff_d == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too, so an aborted operation leaves nothing behind.
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      b_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      b_out_q     <= b_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.diff      = diff_q;
  assign io.b_out     = b_out_q;
  assign io.ovf       = ovf_q;
  assign io.zero      = zero_q;
endmodule

// File: tb/tb_cla_sub_seq.sv
// Scoreboard bench for cla_sub_seq at WIDTH = 16: the driver pushes expected
// results on each accepted operand set, the monitor pops and compares on output.
module tb_cla_sub_seq;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] diff;
    logic        bo;
    logic        ov;
    logic        z;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  exp_t sb[$];
  bit   seen_valid = 1'b0;

  cla_sub_seq_if #(.WIDTH(WIDTH)) ifc ();

  cla_sub_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Single driver for out_ready, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ifc.out_ready = 1'b0;
      1:       ifc.out_ready = 1'b1;
      default: ifc.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every cycle the result is presented, pops on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(ifc.out_valid), 32'd0);
      end else begin
        if (!seen_valid) begin
          check("latency", 32'(cyc - sb[0].acc_cyc), 32'(NSLICE));
          seen_valid = 1'b1;
        end
        check("diff",  32'(ifc.diff),  32'(sb[0].diff));
        check("b_out", 32'(ifc.b_out), 32'(sb[0].bo));
        check("ovf",   32'(ifc.ovf),   32'(sb[0].ov));
        check("zero",  32'(ifc.zero),  32'(sb[0].z));
        check("in_ready_in_done", 32'(ifc.in_ready), 32'd0);
        if (ifc.out_ready === 1'b1) begin
          void'(sb.pop_front());
          seen_valid = 1'b0;
        end
      end
    end
  end

  // Present one operand set, wait (bounded) for acceptance, push the expectation.
  task automatic send(input vec_t v);
    int waited = 0;
    exp_t e;
    @(negedge clk);
    ifc.a = v.a; ifc.b = v.b; ifc.b_in = v.bin; ifc.in_valid = 1'b1;
    while (ifc.in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      timeout_fail("accept");
      ifc.in_valid = 1'b0;
      return;
    end
    e.diff = v.diff; e.bo = v.bo; e.ov = v.ov; e.z = v.z; e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.a = 16'hDEAD; ifc.b = 16'hBEEF; ifc.b_in = 1'b1;
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) timeout_fail(name);
  endtask

  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    vec_t v;
    logic [16:0] t;
    t = {1'b0, a} - {1'b0, b} - 17'(bin);
    v.a = a; v.b = b; v.bin = bin;
    v.diff = t[15:0];
    v.bo   = t[16];
    v.ov   = (a[15] != b[15]) && (t[15] != a[15]);
    v.z    = (t[15:0] == 16'h0);
    return v;
  endfunction

  vec_t dir[8] = '{
    '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0},
    '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
    '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1},
    '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0},
    '{16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
    '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0},
    '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0}
  };

  initial begin
    vec_t v;
    int waited;
    ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.b_in = 1'b0; ifc.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_diff",      32'(ifc.diff),      32'd0);
    check("rst_flags",     32'({ifc.b_out, ifc.ovf, ifc.zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back to back with out_ready high.
    foreach (dir[i]) send(dir[i]);
    drain("drain_directed");

    // Backpressure: result held while in_valid toggles; nothing captured.
    ready_mode = 0;
    v = '{16'h00FF, 16'h0F0F, 1'b0, 16'hF1F0, 1'b1, 1'b0, 1'b0};
    send(v);
    waited = 0;
    while (ifc.out_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) timeout_fail("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ifc.in_valid = ~ifc.in_valid;
      ifc.a = 16'(i * 16'h1111); ifc.b = 16'h0001; ifc.b_in = 1'b0;
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ready_mode = 1;
    send('{16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, 1'b0});
    drain("drain_bp");

    // Random operands with random output stalls against the reference model.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send(model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1))));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ready_mode = 1;
    drain("drain_random");

    // Flags are now set from a signed-overflow result; abort a new operation mid-BUSY.
    send(dir[7]);
    drain("drain_pre_reset");
    send(model(16'hFFFF, 16'h0000, 1'b0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(ifc.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_diff",      32'(ifc.diff),      32'd0);
    check("mid_rst_b_out",     32'(ifc.b_out),     32'd0);
    check("mid_rst_ovf",       32'(ifc.ovf),       32'd0);
    check("mid_rst_zero",      32'(ifc.zero),      32'd0);
    sb.delete();
    seen_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send('{16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    drain("drain_post_reset");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cla_sub_seq.md
Name: cla_sub_seq

Overview:
- Multi-cycle subtractor for the adder datapath library.
- Computes diff = a − b − b_in over a WIDTH-bit operand, four bits per clock, reusing a single 4-bit lookahead slice as a + ~b + ~b_in.
- The borrow is held in a register between slices.
- Valid/ready handshakes on input and output let it sit between CGRA PE stages as the subtracting counterpart of the lookahead adder blocks.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived: number of 4-bit slices. Local; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operands a, b, b_in are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow-in.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a − b − b_in, modulo 2^WIDTH.
- b_out  output  1  borrow-out; 1 iff a < b + b_in (unsigned).
- ovf  output  1  signed overflow of the two's-complement subtraction.
- zero  output  1  diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - diff = 0; b_out = 0; ovf = 0; zero = 0; slice counter = 0; borrow register = 0.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
    - On in_valid & in_ready: capture a, b, b_in into registers; carry register = ~b_in; counter = 0; go to BUSY.
  - BUSY: in_ready = 0, out_valid = 0.
    - Each cycle, slice k = counter computes 4 bits of a[4k+3:4k] + ~b[4k+3:4k] + carry using generate/propagate lookahead.
    - Write the slice sum into diff[4k+3:4k] and the slice carry-out into the carry register.
    - After slice NSLICE−1: b_out = ~carry-out; ovf = (a_msb ≠ b_msb) & (diff_msb ≠ a_msb); zero = (diff == 0) over the full final value; go to DONE.
    - Otherwise counter increments.
  - DONE: out_valid = 1, in_ready = 0; diff, b_out, ovf, zero held stable.
    - On out_ready: out_valid falls next edge; go to IDLE.
- Latency: accepting edge T, out_valid high after edge T+NSLICE, i.e. NSLICE cycles.
  - Minimum initiation interval is NSLICE+2 cycles with out_ready held high.
- Handshake rules:
  - Inputs are sampled only on the accepting edge; a, b, b_in may change freely afterwards.
  - in_valid while not in IDLE is ignored and not queued.
  - out_ready while out_valid = 0 has no effect.
  - out_valid stays asserted and outputs stay stable until out_ready is seen, regardless of in_valid.
- Intermediate outputs: diff may show partially written slices during BUSY and must not be consumed then; b_out, ovf and zero update only on the BUSY→DONE edge.
- Arithmetic: diff wraps modulo 2^WIDTH; b_in = 1 with a = b gives diff = all ones, b_out = 1.
- WIDTH = 4 gives a single BUSY cycle.
- Reset mid-operation: any state returns immediately to the IDLE reset values; the in-flight result is discarded.

Test Plan:
- Reset check: hold rst_n low mid-BUSY → in_ready = 1, out_valid = 0, diff = 0, all flags 0, asynchronously and without a clock edge.
- WIDTH=16, a=0x1234, b=0x0234, b_in=0 → out_valid after 4 cycles; diff=0x1000, b_out=0, ovf=0, zero=0.
- a=0x0000, b=0x0001, b_in=0 → diff=0xFFFF, b_out=1, ovf=0, zero=0.
  - Then a=0x0005, b=0x0004, b_in=1 → diff=0x0000, zero=1, b_out=0.
- Signed overflow: a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1, b_out=0.
  - Then a=0x7FFF, b=0xFFFF → diff=0x8000, ovf=1, b_out=1.
- Backpressure: hold out_ready=0 for 10 cycles while toggling in_valid → outputs stable, in_ready=0, no second capture.
  - Then raise out_ready → IDLE, next operand accepted.
- Random: 10k random a, b, b_in at WIDTH=4, 16 and 32 with random valid/ready stalls → diff, b_out, ovf and zero match a reference model.
